// File: rtl/crg_seq_ctrl.sv
// CRGU power-up/power-down sequencer: orders efuse load, top start and data/fifo
// clock enables on run/stop, and stretches software reset requests into cmd_reset.
module crg_seq_ctrl #(
    parameter int EFUSE_TIMEOUT = 64,
    parameter int SETTLE        = 512,
    parameter int DRAIN_MAX     = 256,
    parameter int RST_PULSE     = 4,
    parameter int CNT_W         = 10
) (
    input  logic       clk_6p5m_reg,
    input  logic       rst_reg_n,
    input  logic       rg_run,
    input  logic       rg_fifo_en,
    input  logic       sw_rst_req,
    input  logic       efuse_done,
    input  logic       fifo_empty,
    output logic       rg_efuse_en,
    output logic       rg_top_start,
    output logic       rg_fifo_clk_en,
    output logic       data_ctrl_en,
    output logic       cmd_reset,
    output logic       busy,
    output logic       efuse_err,
    output logic [2:0] seq_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_EFUSE = 3'd1,
        S_START = 3'd2,
        S_RUN   = 3'd3,
        S_DRAIN = 3'd4,
        S_STOP  = 3'd5,
        S_SRST  = 3'd6
    } state_t;

    // Reload values: a state with load N-1 is left on the edge after the counter hits 0,
    // giving exactly N cycles of residency.
    localparam logic [CNT_W-1:0] EFUSE_LOAD  = CNT_W'(EFUSE_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0] DRAIN_LOAD  = CNT_W'(DRAIN_MAX - 1);
    localparam logic [CNT_W-1:0] RST_LOAD    = CNT_W'(RST_PULSE - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             cnt_zero;
    logic             err_set, err_clr;

    logic efuse_en_nxt, top_start_nxt, fifo_clk_en_nxt, data_en_nxt;
    logic cmd_reset_nxt, busy_nxt, efuse_err_nxt;

    assign cnt_zero = (cnt == '0);

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_nxt = state;
        cnt_nxt   = cnt_zero ? '0 : cnt - CNT_W'(1);
        err_set   = 1'b0;
        err_clr   = 1'b0;

        if (sw_rst_req) begin
            state_nxt = S_SRST;
            cnt_nxt   = RST_LOAD;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (rg_run) begin
                        state_nxt = S_EFUSE;
                        cnt_nxt   = EFUSE_LOAD;
                        err_clr   = 1'b1;
                    end
                end
                S_EFUSE: begin
                    if (!rg_run) begin
                        state_nxt = S_IDLE;
                    end else if (efuse_done || cnt_zero) begin
                        state_nxt = S_START;
                        cnt_nxt   = SETTLE_LOAD;
                        err_set   = !efuse_done;
                    end
                end
                S_START: begin
                    if (cnt_zero) state_nxt = S_RUN;
                end
                S_RUN: begin
                    if (!rg_run) begin
                        state_nxt = S_DRAIN;
                        cnt_nxt   = DRAIN_LOAD;
                    end
                end
                S_DRAIN: begin
                    if (fifo_empty || cnt_zero) begin
                        state_nxt = S_STOP;
                        cnt_nxt   = SETTLE_LOAD;
                    end
                end
                S_STOP, S_SRST: begin
                    if (cnt_zero) state_nxt = S_IDLE;
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state so they change on the same edge as seq_state.
    always_comb begin
        efuse_en_nxt    = (state_nxt == S_EFUSE);
        top_start_nxt   = (state_nxt == S_START) || (state_nxt == S_RUN) || (state_nxt == S_DRAIN);
        data_en_nxt     = (state_nxt == S_RUN);
        cmd_reset_nxt   = (state_nxt == S_SRST);
        busy_nxt        = (state_nxt != S_IDLE) && (state_nxt != S_RUN);
        efuse_err_nxt   = err_set | (efuse_err & ~err_clr);
        fifo_clk_en_nxt = 1'b0;
        if ((state_nxt == S_START) || (state_nxt == S_RUN)) begin
            fifo_clk_en_nxt = rg_fifo_en;
        end else if (state_nxt == S_DRAIN) begin
            fifo_clk_en_nxt = rg_fifo_clk_en;
        end
    end

    always_ff @(posedge clk_6p5m_reg or negedge rst_reg_n) begin
        if (!rst_reg_n) begin
            state          <= S_IDLE;
            cnt            <= '0;
            rg_efuse_en    <= 1'b0;
            rg_top_start   <= 1'b0;
            rg_fifo_clk_en <= 1'b0;
            data_ctrl_en   <= 1'b0;
            cmd_reset      <= 1'b0;
            busy           <= 1'b0;
            efuse_err      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state          <= state_nxt;
            cnt            <= cnt_nxt;
            rg_efuse_en    <= efuse_en_nxt;
            rg_top_start   <= top_start_nxt;
            rg_fifo_clk_en <= fifo_clk_en_nxt;
            data_ctrl_en   <= data_en_nxt;
            cmd_reset      <= cmd_reset_nxt;
            busy           <= busy_nxt;
            efuse_err      <= efuse_err_nxt;
        end
    end

    assign seq_state = state;

endmodule

// File: tb/tb_crg_seq_ctrl.sv
// Self-checking bench for crg_seq_ctrl: directed scenarios plus random stimulus,
// every cycle compared against a residency-based behavioural model.
module tb_crg_seq_ctrl;

    localparam int T_EFUSE = 8;
    localparam int T_SETTLE = 4;
    localparam int T_DRAIN = 6;
    localparam int T_RST = 3;

    logic       clk_6p5m_reg = 1'b0;
    logic       rst_reg_n;
    logic       rg_run, rg_fifo_en, sw_rst_req, efuse_done, fifo_empty;
    logic       rg_efuse_en, rg_top_start, rg_fifo_clk_en, data_ctrl_en;
    logic       cmd_reset, busy, efuse_err;
    logic [2:0] seq_state;

    int n_checks = 0;
    int n_pass = 0;

    // Model: state code, cycles spent in it so far (1 on the first cycle), sticky error, fifo gate.
    int m_st;
    int m_age;
    bit m_err;
    bit m_fifo;

    crg_seq_ctrl #(
        .EFUSE_TIMEOUT(T_EFUSE),
        .SETTLE       (T_SETTLE),
        .DRAIN_MAX    (T_DRAIN),
        .RST_PULSE    (T_RST),
        .CNT_W        (10)
    ) dut (
        .clk_6p5m_reg  (clk_6p5m_reg),
        .rst_reg_n     (rst_reg_n),
        .rg_run        (rg_run),
        .rg_fifo_en    (rg_fifo_en),
        .sw_rst_req    (sw_rst_req),
        .efuse_done    (efuse_done),
        .fifo_empty    (fifo_empty),
        .rg_efuse_en   (rg_efuse_en),
        .rg_top_start  (rg_top_start),
        .rg_fifo_clk_en(rg_fifo_clk_en),
        .data_ctrl_en  (data_ctrl_en),
        .cmd_reset     (cmd_reset),
        .busy          (busy),
        .efuse_err     (efuse_err),
        .seq_state     (seq_state)
    );

    always #5 clk_6p5m_reg = ~clk_6p5m_reg;

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    function automatic logic [9:0] outs();
        return {seq_state, efuse_err, busy, cmd_reset, data_ctrl_en,
                rg_fifo_clk_en, rg_top_start, rg_efuse_en};
    endfunction

    function automatic logic [9:0] model_outs();
        logic [2:0] s;
        s = 3'(m_st);
        return {s, m_err, !(m_st == 0 || m_st == 3), m_st == 6, m_st == 3,
                m_fifo, (m_st >= 2 && m_st <= 4), m_st == 1};
    endfunction

    function automatic void model_reset();
        m_st = 0; m_age = 1; m_err = 0; m_fifo = 0;
    endfunction

    // Advance the model on current inputs, clock the DUT, then compare all outputs.
    task automatic tick();
        int ns;
        ns = m_st;
        if (sw_rst_req) ns = 6;
        else case (m_st)
            0: if (rg_run) begin ns = 1; m_err = 0; end
            1: if (!rg_run) ns = 0;
               else if (efuse_done) ns = 2;
               else if (m_age >= T_EFUSE) begin ns = 2; m_err = 1; end
            2: if (m_age >= T_SETTLE) ns = 3;
            3: if (!rg_run) ns = 4;
            4: if (fifo_empty || m_age >= T_DRAIN) ns = 5;
            5: if (m_age >= T_SETTLE) ns = 0;
            6: if (m_age >= T_RST) ns = 0;
            default: ns = 0;
        endcase
        m_age = (ns != m_st || sw_rst_req) ? 1 : m_age + 1;
        if (ns == 2 || ns == 3) m_fifo = rg_fifo_en;
        else if (ns != 4) m_fifo = 0;
        m_st = ns;
        @(posedge clk_6p5m_reg);
        #1;
        check("outs", 32'(outs()), 32'(model_outs()));
    endtask

    // Count cycles spent in state st starting from its current cycle, bounded.
    task automatic residency(input logic [2:0] st, output int n);
        n = 0;
        while (seq_state == st && n < 50) begin
            n++;
            tick();
        end
    endtask

    int n;

    initial begin
        rst_reg_n = 1'b0;
        rg_run = 0; rg_fifo_en = 1; sw_rst_req = 0; efuse_done = 0; fifo_empty = 0;
        model_reset();
        #12;
        check("reset_outs", 32'(outs()), 32'd0);
        rst_reg_n = 1'b1;
        tick();

        // Normal start, efuse_done on the third EFUSE cycle
        rg_run = 1;
        tick();
        n = 0;
        while (rg_efuse_en && n < 20) begin
            n++;
            if (n == 3) efuse_done = 1;
            tick();
        end
        efuse_done = 0;
        check("efuse_len", n, 3);
        check("top_start_rise", rg_top_start, 1);
        n = 0;
        while (!data_ctrl_en && n < 20) begin
            n++;
            tick();
        end
        check("start_len", n, T_SETTLE);
        check("run_state", seq_state, 3);
        check("run_busy", busy, 0);

        // FIFO clock gate follows rg_fifo_en with one cycle of latency
        for (int i = 0; i < 8; i++) begin
            rg_fifo_en = logic'($urandom_range(1));
            tick();
            check("fifo_follow", rg_fifo_clk_en, rg_fifo_en);
        end

        // Stop with a full drain timeout
        rg_run = 0; fifo_empty = 0;
        tick();
        check("data_off", data_ctrl_en, 0);
        residency(3'd4, n);
        check("drain_len", n, T_DRAIN);
        check("stop_enables", {rg_efuse_en, rg_top_start, rg_fifo_clk_en, data_ctrl_en}, 0);
        residency(3'd5, n);
        check("stop_len", n, T_SETTLE);
        check("idle_after_stop", seq_state, 0);

        // Early drain exit on the second DRAIN cycle
        rg_run = 1; efuse_done = 1;
        tick();
        tick();
        efuse_done = 0;
        residency(3'd2, n);
        rg_run = 0;
        tick();
        tick();
        fifo_empty = 1;
        tick();
        fifo_empty = 0;
        check("early_drain", seq_state, 5);
        residency(3'd5, n);

        // EFUSE timeout, then the next IDLE->EFUSE clears the error
        rg_run = 1;
        tick();
        residency(3'd1, n);
        check("efuse_timeout_len", n, T_EFUSE);
        check("efuse_err_set", efuse_err, 1);
        residency(3'd2, n);
        check("timeout_reaches_run", seq_state, 3);
        rg_run = 0; fifo_empty = 1;
        tick();
        tick();
        fifo_empty = 0;
        residency(3'd5, n);
        check("efuse_err_sticky", efuse_err, 1);
        rg_run = 1;
        tick();
        check("efuse_err_clear", efuse_err, 0);

        // Abort from EFUSE, and abort coinciding with efuse_done
        rg_run = 0;
        tick();
        check("abort_idle", seq_state, 0);
        rg_run = 1;
        tick();
        rg_run = 0; efuse_done = 1;
        tick();
        efuse_done = 0;
        check("abort_vs_done", seq_state, 0);

        // Soft reset during START
        rg_run = 1; efuse_done = 1;
        tick();
        tick();
        efuse_done = 0;
        tick();
        sw_rst_req = 1;
        tick();
        sw_rst_req = 0; rg_run = 0;
        check("srst_enables", {cmd_reset, rg_efuse_en, rg_top_start, rg_fifo_clk_en, data_ctrl_en}, 5'b10000);
        residency(3'd6, n);
        check("srst_len", n, T_RST);
        check("srst_idle", seq_state, 0);

        // Async reset on SRST cycle 2 clears everything immediately
        sw_rst_req = 1;
        tick();
        sw_rst_req = 0;
        tick();
        #1;
        rst_reg_n = 1'b0;
        #1;
        check("async_reset", 32'(outs()), 32'd0);
        model_reset();
        rst_reg_n = 1'b1;

        // Randomized phase
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(15) == 0) rg_run = ~rg_run;
            if ($urandom_range(7) == 0) rg_fifo_en = ~rg_fifo_en;
            efuse_done = ($urandom_range(5) == 0);
            fifo_empty = ($urandom_range(4) == 0);
            sw_rst_req = ($urandom_range(59) == 0);
            tick();
        end
        sw_rst_req = 0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
